// File: rtl/step_counter_pkg.sv
// Shared constants for the step counter slice.
// Ports: none (package only).
// Holds direction and limit-mode encodings used by step_counter and its bench.
package step_counter_pkg;

  // Direction encoding for i_dir.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Limit behaviour selected by the SATURATE parameter.
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

endpackage : step_counter_pkg

// File: rtl/addsub_n.sv
// Purpose: combinational WIDTH-bit adder/subtractor with carry/borrow out.
// Latency: 0 cycles (pure combinational, no state).
// Ports: i_a, i_b operands; i_sub selects a-b (1) or a+b (0);
//        o_res low WIDTH bits of the result; o_cout carry (add) or borrow (sub).
module addsub_n #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_res,
  output logic             o_cout
);

  logic [WIDTH:0] w_ext;

  // Both operands are zero-extended by one bit; for a subtraction the top bit
  // of the WIDTH+1 result is set exactly when b > a, i.e. a borrow occurred.
  always_comb begin
    if (i_sub) begin
      w_ext = {1'b0, i_a} - {1'b0, i_b};
    end else begin
      w_ext = {1'b0, i_a} + {1'b0, i_b};
    end
  end

  assign o_res  = w_ext[WIDTH-1:0];
  assign o_cout = w_ext[WIDTH];

endmodule : addsub_n

// File: rtl/step_counter.sv
// Purpose: up/down counter with variable step, parallel load, wrap or clamp at
//          the limits, one-cycle limit pulse and a sticky limit flag.
// Latency: 1 cycle from inputs to o_count/o_limit/o_ovf_sticky; o_zero/o_max
//          decode the count register only. No backpressure; inputs act every edge.
// Ports: i_clk, i_rst (sync active-high); i_en, i_dir, i_step step control;
//        i_load, i_load_val parallel load; i_clr_flags clears the sticky flag;
//        o_count, o_limit, o_ovf_sticky, o_zero, o_max status outputs.
module step_counter
  import step_counter_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               STEP_W    = 4,
  parameter int               SATURATE  = MODE_WRAP,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_dir,
  input  logic [STEP_W-1:0] i_step,
  input  logic              i_load,
  input  logic [WIDTH-1:0]  i_load_val,
  input  logic              i_clr_flags,
  output logic [WIDTH-1:0]  o_count,
  output logic              o_limit,
  output logic              o_ovf_sticky,
  output logic              o_zero,
  output logic              o_max
);

  logic [WIDTH-1:0] r_count;
  logic             r_limit;
  logic             r_ovf_sticky;

  logic [WIDTH-1:0] w_step_ext;
  logic             w_sub;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_event;
  logic [WIDTH-1:0] w_clamp_val;
  logic [WIDTH-1:0] w_step_val;

  assign w_step_ext = WIDTH'(i_step);
  assign w_sub      = (i_dir == DIR_DOWN);

  addsub_n #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .i_a    (r_count),
    .i_b    (w_step_ext),
    .i_sub  (w_sub),
    .o_res  (w_sum),
    .o_cout (w_cout)
  );

  // A zero step can never carry or borrow, so it never raises an event.
  // Load has priority over stepping, so a step under load is not an event.
  assign w_event = i_en & ~i_load & w_cout;

  // Clamp target: top of range going up, bottom going down.
  assign w_clamp_val = (i_dir == DIR_UP) ? '1 : '0;

  // Wrap mode keeps the modulo result; saturate mode clamps on an event.
  assign w_step_val = (SATURATE == MODE_SAT && w_cout) ? w_clamp_val : w_sum;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count      <= RESET_VAL;
      r_limit      <= 1'b0;
      r_ovf_sticky <= 1'b0;
    end else begin
      if (i_load) begin
        r_count <= i_load_val;
        r_limit <= 1'b0;
      end else if (i_en) begin
        r_count <= w_step_val;
        r_limit <= w_cout;
      end else begin
        r_limit <= 1'b0;
      end

      // A set on the same edge as a clear wins.
      if (w_event) begin
        r_ovf_sticky <= 1'b1;
      end else if (i_clr_flags) begin
        r_ovf_sticky <= 1'b0;
      end
    end
  end

  assign o_count      = r_count;
  assign o_limit      = r_limit;
  assign o_ovf_sticky = r_ovf_sticky;
  assign o_zero       = (r_count == '0);
  assign o_max        = (r_count == '1);

endmodule : step_counter

// File: tb/tb_step_counter.sv
// Scoreboard bench: stimulus drives a wrap-mode and a saturate-mode counter in
// parallel and pushes the reference model's expected state per cycle; a
// monitor pops one entry per DUT per cycle and compares every output.
module tb_step_counter;
  import step_counter_pkg::*;

  localparam int          W     = 16;
  localparam int          SW    = 4;
  localparam logic [15:0] RVAL  = 16'h0005;
  localparam longint      MODV  = 64'd65536;

  typedef struct {
    logic [15:0] cnt;
    logic        lim;
    logic        st;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          dir = 1'b0;
  logic [SW-1:0] stp = '0;
  logic          load = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic          clr = 1'b0;

  logic [W-1:0] cnt_w, cnt_s;
  logic         lim_w, lim_s, st_w, st_s, zero_w, zero_s, max_w, max_s;

  exp_t q_w[$];
  exp_t q_s[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state, index 0 = wrap mode, 1 = saturate mode.
  longint m_cnt[2];
  bit     m_st[2];

  always #5 clk = ~clk;

  step_counter #(
    .WIDTH(W), .STEP_W(SW), .SATURATE(MODE_WRAP), .RESET_VAL(RVAL)
  ) dut_w (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_dir(dir), .i_step(stp),
    .i_load(load), .i_load_val(load_val), .i_clr_flags(clr),
    .o_count(cnt_w), .o_limit(lim_w), .o_ovf_sticky(st_w),
    .o_zero(zero_w), .o_max(max_w)
  );

  step_counter #(
    .WIDTH(W), .STEP_W(SW), .SATURATE(MODE_SAT), .RESET_VAL(RVAL)
  ) dut_s (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_dir(dir), .i_step(stp),
    .i_load(load), .i_load_val(load_val), .i_clr_flags(clr),
    .o_count(cnt_s), .o_limit(lim_s), .o_ovf_sticky(st_s),
    .o_zero(zero_s), .o_max(max_s)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and push the expected post-edge state.
  task automatic cyc(input bit r, input bit ld, input logic [15:0] lv,
                     input bit e, input bit d, input int s, input bit c);
    exp_t x;
    @(negedge clk);
    rst = r; load = ld; load_val = lv; en = e; dir = d;
    stp = SW'(s); clr = c;
    for (int k = 0; k < 2; k++) begin
      longint v;
      bit     lim;
      v   = m_cnt[k];
      lim = 1'b0;
      if (r) begin
        v = longint'(RVAL);
        m_st[k] = 1'b0;
      end else begin
        if (ld) begin
          v = longint'(lv);
        end else if (e) begin
          if (d) begin
            v = v + s;
            if (v >= MODV) begin
              lim = 1'b1;
              v = (k == 1) ? MODV - 1 : v - MODV;
            end
          end else begin
            if (s > v) begin
              lim = 1'b1;
              v = (k == 1) ? 0 : v + MODV - s;
            end else begin
              v = v - s;
            end
          end
        end
        if (lim) m_st[k] = 1'b1;
        else if (c) m_st[k] = 1'b0;
      end
      m_cnt[k] = v;
      x.cnt = v[15:0];
      x.lim = lim;
      x.st  = m_st[k];
      if (k == 0) q_w.push_back(x);
      else        q_s.push_back(x);
    end
  endtask

  // Monitor: one output observation per DUT per clock, sampled after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q_w.size() > 0) begin
        x = q_w.pop_front();
        chk("wrap_count", 64'(cnt_w), 64'(x.cnt));
        chk("wrap_limit", 64'(lim_w), 64'(x.lim));
        chk("wrap_sticky", 64'(st_w), 64'(x.st));
        chk("wrap_zero", 64'(zero_w), 64'(x.cnt == 16'h0000));
        chk("wrap_max", 64'(max_w), 64'(x.cnt == 16'hFFFF));
      end
      if (q_s.size() > 0) begin
        x = q_s.pop_front();
        chk("sat_count", 64'(cnt_s), 64'(x.cnt));
        chk("sat_limit", 64'(lim_s), 64'(x.lim));
        chk("sat_sticky", 64'(st_s), 64'(x.st));
        chk("sat_zero", 64'(zero_s), 64'(x.cnt == 16'h0000));
        chk("sat_max", 64'(max_s), 64'(x.cnt == 16'hFFFF));
      end
    end
  end

  initial begin
    logic [15:0] edge_vals[6];
    edge_vals[0] = 16'h0000; edge_vals[1] = 16'h0001; edge_vals[2] = 16'h0007;
    edge_vals[3] = 16'hFFF8; edge_vals[4] = 16'hFFFE; edge_vals[5] = 16'hFFFF;
    m_cnt[0] = 0; m_cnt[1] = 0; m_st[0] = 0; m_st[1] = 0;

    // Reset, then three up steps of 1: 5,6,7,8.
    cyc(1, 0, 16'h0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 16'h0, 1, 1, 1, 0);
    // Load near top, wrap/clamp up by 3, then down by 2.
    cyc(0, 1, 16'hFFFE, 0, 0, 0, 0);
    cyc(0, 0, 16'h0, 1, 1, 3, 0);
    cyc(0, 0, 16'h0, 1, 0, 2, 0);
    cyc(0, 0, 16'h0, 0, 0, 0, 0);
    // Load 2, two down steps of 4.
    cyc(0, 1, 16'h0002, 0, 0, 0, 0);
    cyc(0, 0, 16'h0, 1, 0, 4, 0);
    cyc(0, 0, 16'h0, 1, 0, 4, 0);
    // Load wins over step on the same edge.
    cyc(0, 1, 16'h1234, 1, 1, 5, 0);
    // Zero step holds.
    cyc(0, 0, 16'h0, 1, 1, 0, 0);
    // Clear together with a wrap event (set wins), then a plain clear.
    cyc(0, 0, 16'h0, 0, 0, 0, 1);
    cyc(0, 1, 16'hFFFF, 0, 0, 0, 0);
    cyc(0, 0, 16'h0, 1, 1, 1, 1);
    cyc(0, 0, 16'h0, 0, 0, 0, 1);
    // Set sticky again, then reset together with a load.
    cyc(0, 1, 16'h0000, 0, 0, 0, 0);
    cyc(0, 0, 16'h0, 1, 0, 1, 0);
    cyc(1, 1, 16'hABCD, 1, 1, 7, 1);
    cyc(0, 0, 16'h0, 1, 1, 2, 0);

    // Randomised traffic, biased toward the limits.
    for (int i = 0; i < 600; i++) begin
      int unsigned sel;
      logic [15:0] lv;
      sel = $urandom_range(99);
      lv  = (($urandom_range(1) == 1) ? edge_vals[$urandom_range(5)] : 16'($urandom));
      cyc((sel < 2), (sel >= 2 && sel < 12), lv,
          ($urandom_range(3) != 0), 1'($urandom), int'($urandom_range(15)),
          ($urandom_range(7) == 0));
    end

    repeat (3) @(negedge clk);
    n_cmp++;
    if (q_w.size() != 0 || q_s.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d/%0d entries left, expected 0", q_w.size(), q_s.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_step_counter
